// File: rtl/mul_pkg.sv
// Shared types and sizing constants for the iterative shift-add multiplier.
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the EX stage: stalls the pipe while iterating
// and presents a registered 2*WIDTH product for one cycle with done.
module mul_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [0:WIDTH-1] op_a,
   input  logic [0:WIDTH-1] op_b,
   output logic             mul_stall,
   output logic [0:WIDTH-1] result,
   output logic [0:WIDTH-1] result_hi,
   output logic             overflow,
   output logic             done
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   mul_state_t          state_q, state_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0]    mplier_q, mplier_d;
   logic [2*WIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                neg_q, neg_d;
   logic                sgn_q, sgn_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [WIDTH-1:0]    result_hi_q, result_hi_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic                stall_s;
   logic [2*WIDTH-1:0]  addend_s;
   logic [2*WIDTH-1:0]  sum_s;
   logic [2*WIDTH-1:0]  prod_s;
   logic                ovf_s;

   // Magnitude of an operand; the most-negative value maps to itself as unsigned.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
      logic [WIDTH-1:0] m;
      if (sgn && v[WIDTH-1]) begin
         m = ~v + ONE_W;
      end else begin
         m = v;
      end
      return m;
   endfunction

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and raw stall request.
   always_comb begin
      state_d = state_q;
      stall_s = 1'b0;
      case (state_q)
         IDLE: begin
            stall_s = start;
            if (start) begin
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            stall_s = 1'b1;
            if (count_q == LAST_CNT) begin
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            stall_s = 1'b0;
            state_d = IDLE;
         end
         default: begin
            stall_s = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Partial-product step, final sign fix-up and signed overflow detection.
   always_comb begin
      if (mplier_q[0]) begin
         addend_s = {{WIDTH{1'b0}}, mcand_q} << count_q;
      end else begin
         addend_s = {(2*WIDTH){1'b0}};
      end
      sum_s = acc_q + addend_s;
      if (neg_q) begin
         prod_s = ~sum_s + ONE_2W;
      end else begin
         prod_s = sum_s;
      end
      ovf_s = sgn_q & (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
   end

   // Datapath next-state: operands latched at start, result written on the last iteration.
   always_comb begin
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      count_d     = count_q;
      neg_d       = neg_q;
      sgn_d       = sgn_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = mag_f(op_a, is_signed);
               mplier_d = mag_f(op_b, is_signed);
               neg_d    = is_signed & (op_a[0] ^ op_b[0]);
               sgn_d    = is_signed;
               acc_d    = {(2*WIDTH){1'b0}};
               count_d  = {CNT_W{1'b0}};
            end else begin
               mcand_d  = mcand_q;
               mplier_d = mplier_q;
            end
         end
         BUSY: begin
            acc_d    = sum_s;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_ONE;
            if (count_q == LAST_CNT) begin
               result_d    = prod_s[WIDTH-1:0];
               result_hi_d = prod_s[2*WIDTH-1:WIDTH];
               ovf_d       = ovf_s;
               done_d      = 1'b1;
            end else begin
               done_d      = 1'b0;
            end
         end
         DONE: begin
            done_d = 1'b0;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mcand_q     <= {WIDTH{1'b0}};
         mplier_q    <= {WIDTH{1'b0}};
         acc_q       <= {(2*WIDTH){1'b0}};
         count_q     <= {CNT_W{1'b0}};
         neg_q       <= 1'b0;
         sgn_q       <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         result_hi_q <= {WIDTH{1'b0}};
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         neg_q       <= neg_d;
         sgn_q       <= sgn_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   // The stall must be combinational so the freeze lands in the cycle the multiply reaches EX.
   assign mul_stall = reset & stall_s;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign overflow  = ovf_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed, table-driven bench for mul_unit with hand-computed products plus
// back-to-back and reset-mid-operation sequences.
module tb_mul_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [0:31] op_a;
   logic [0:31] op_b;
   logic        mul_stall;
   logic [0:31] result;
   logic [0:31] result_hi;
   logic        overflow;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   mul_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .mul_stall (mul_stall),
      .result    (result),
      .result_hi (result_hi),
      .overflow  (overflow),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic        drop;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Starts one multiply at the next cycle and watches it until done or the budget runs out.
   task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic drop, output int done_cyc, output int stall_cnt,
                          output int stall_bad, output logic [31:0] lo,
                          output logic [31:0] hi, output logic ovf);
      done_cyc  = -1;
      stall_cnt = 0;
      stall_bad = 0;
      lo        = 32'h0;
      hi        = 32'h0;
      ovf       = 1'b0;
      @(posedge clock); #1;
      start     = 1'b1;
      is_signed = sgn;
      op_a      = a;
      op_b      = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (mul_stall === 1'b1) stall_cnt++;
         if (mul_stall === done) stall_bad++;
         if (done === 1'b1) begin
            done_cyc = c;
            lo  = result;
            hi  = result_hi;
            ovf = overflow;
            break;
         end
         @(posedge clock); #1;
         if (drop && c == 4) start = 1'b0;
         op_a      = ~a;
         op_b      = ~b;
         is_signed = ~sgn;
      end
   endtask

   vec_t        vecs[12];
   int          dc, sc, sb, dc2, sc2, sb2, done_seen;
   logic [31:0] lo, hi, lo2, hi2;
   logic        ovf, ovf2;

   initial begin
      vecs[0]  = '{1'b0, 32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h00000000, 1'b1};
      vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[4]  = '{1'b1, 32'h7FFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFE, 32'h00000000, 1'b1};
      vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'h00000000, 1'b0};
      vecs[6]  = '{1'b0, 32'h80000000, 32'h00000002, 1'b0, 32'h00000000, 32'h00000001, 1'b0};
      vecs[7]  = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 32'h40000000, 1'b1};
      vecs[8]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
      vecs[9]  = '{1'b1, 32'h00000005, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
      vecs[10] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFF1, 32'h00000004, 1'b0};
      vecs[11] = '{1'b0, 32'h12345678, 32'h00000010, 1'b1, 32'h23456780, 32'h00000001, 1'b0};

      reset     = 1'b0;
      start     = 1'b1;
      is_signed = 1'b0;
      op_a      = 32'h3;
      op_b      = 32'h4;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_stall", {63'h0, mul_stall}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      check("rst_ovf", {63'h0, overflow}, 64'h0);
      check("rst_result", {result_hi, result}, 64'h0);
      @(posedge clock); #1;
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      for (int i = 0; i < 12; i++) begin
         run_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].drop, dc, sc, sb, lo, hi, ovf);
         check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'd33);
         check($sformatf("v%0d_stall_cycles", i), 64'(sc), 64'd33);
         check($sformatf("v%0d_stall_vs_done", i), 64'(sb), 64'd0);
         check($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].lo});
         check($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].hi});
         check($sformatf("v%0d_ovf", i), {63'h0, ovf}, {63'h0, vecs[i].ovf});
         @(posedge clock); #1;
         start = 1'b0;
         @(negedge clock);
         check($sformatf("v%0d_done_pulse", i), {63'h0, done}, 64'h0);
         check($sformatf("v%0d_hold", i), {result_hi, result}, {vecs[i].hi, vecs[i].lo});
         @(posedge clock);
      end

      // Back-to-back: start stays high through the DONE cycle of the first multiply.
      run_mul(1'b0, 32'd2, 32'd3, 1'b0, dc, sc, sb, lo, hi, ovf);
      run_mul(1'b0, 32'd4, 32'd5, 1'b0, dc2, sc2, sb2, lo2, hi2, ovf2);
      check("b2b_done1_cycle", 64'(dc), 64'd33);
      check("b2b_done2_cycle", 64'(dc + 1 + dc2), 64'd67);
      check("b2b_stall_cycles", 64'(sc + sc2), 64'd66);
      check("b2b_stall_vs_done", 64'(sb + sb2), 64'd0);
      check("b2b_first", {hi, lo}, 64'd6);
      check("b2b_second", {hi2, lo2}, 64'd20);
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);

      // Reset asserted during BUSY cycle 10 discards the operation.
      @(posedge clock); #1;
      start     = 1'b1;
      is_signed = 1'b0;
      op_a      = 32'd12;
      op_b      = 32'd13;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check("midrst_stall_forced", {63'h0, mul_stall}, 64'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("midrst_stall_after", {63'h0, mul_stall}, 64'h0);
      check("midrst_result", {result_hi, result}, 64'h0);
      check("midrst_done", {63'h0, done}, 64'h0);
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (done === 1'b1 || mul_stall === 1'b1) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'd0);

      run_mul(1'b0, 32'd9, 32'd9, 1'b0, dc, sc, sb, lo, hi, ovf);
      check("fresh_done_cycle", 64'(dc), 64'd33);
      check("fresh_product", {hi, lo}, 64'd81);
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
